seg7_scan_capture: RTL and testbench

// - Decodes a multiplexed 7-segment display drive back into hex nibbles (active-low segments, active-low anodes).
// - Used on-board for loopback self-test of the display path and for readback of the processor's debug display.
// - Holds the segment/anode pair until it is stable, decodes it to a nibble and assembles one frame (one nibble per digit).
// - Hands each frame out on a valid/ready handshake.

---
 rtl/seg7_pkg.sv | 80 ++++++++
 rtl/seg7_scan_capture_if.sv | 27 ++
 rtl/seg7_pattern_decode.sv | 12 +
 rtl/seg7_scan_capture.sv | 156 +++++++++++++++
 tb/tb_seg7_scan_capture.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan capture block: segment codes,
// scan FSM states and the encode/decode helpers.
package seg7_pkg;

    // Active-low segment patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DWELL,
        S_HELD
    } scan_state_t;

    typedef struct packed {
        logic       err;
        logic       blank;
        logic [3:0] nibble;
    } seg_decode_t;

    // Hex nibble to active-low segment pattern
    function automatic logic [6:0] seg7_encode(input logic [3:0] nibble);
        logic [6:0] pat;
        case (nibble)
            4'h0: pat = SEG_0;
            4'h1: pat = SEG_1;
            4'h2: pat = SEG_2;
            4'h3: pat = SEG_3;
            4'h4: pat = SEG_4;
            4'h5: pat = SEG_5;
            4'h6: pat = SEG_6;
            4'h7: pat = SEG_7;
            4'h8: pat = SEG_8;
            4'h9: pat = SEG_9;
            4'hA: pat = SEG_A;
            4'hB: pat = SEG_B;
            4'hC: pat = SEG_C;
            4'hD: pat = SEG_D;
            4'hE: pat = SEG_E;
            default: pat = SEG_F;
        endcase
        return pat;
    endfunction

    // Segment pattern to {err, blank, nibble}; blank reads as nibble 0
    function automatic seg_decode_t seg7_decode(input logic [6:0] pattern);
        seg_decode_t d;
        d.err    = 1'b1;
        d.blank  = 1'b0;
        d.nibble = 4'h0;
        if (pattern == SEG_BLANK) begin
            d.err   = 1'b0;
            d.blank = 1'b1;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (pattern == seg7_encode(4'(i))) begin
                    d.err    = 1'b0;
                    d.nibble = 4'(i);
                end
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/seg7_scan_capture_if.sv
// Display-side inputs and frame-side handshake of the scan capture block.
interface seg7_scan_capture_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    logic [6:0]              seg_i;
    logic [NUM_DIGITS-1:0]   an_i;
    logic                    clear_i;
    logic [4*NUM_DIGITS-1:0] value_o;
    logic [NUM_DIGITS-1:0]   blank_o;
    logic                    frame_valid_o;
    logic                    frame_ready_i;
    logic                    err_o;
    logic [IDX_W-1:0]        err_digit_o;
    logic                    overrun_o;

    modport master (
        output seg_i, an_i, clear_i, frame_ready_i,
        input  value_o, blank_o, frame_valid_o, err_o, err_digit_o, overrun_o
    );

    modport slave (
        input  seg_i, an_i, clear_i, frame_ready_i,
        output value_o, blank_o, frame_valid_o, err_o, err_digit_o, overrun_o
    );
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern decoder.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0]  pattern,
    output seg_decode_t result_c
);

    // Table lookup lives in the package so the bench-side encoder stays in sync
    assign result_c = seg7_decode(pattern);

endmodule

// File: rtl/seg7_scan_capture.sv
// Captures a multiplexed 7-segment drive into hex frames, one nibble per digit,
// and hands complete frames out on a valid/ready handshake.
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS    = 4,
    parameter int unsigned STABLE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    seg7_scan_capture_if.slave  bus
);

    localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_W  = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned PAIR_W = NUM_DIGITS + 7;
    localparam logic [CNT_W-1:0] DWELL_MAX = CNT_W'(STABLE_CYCLES);

    logic [PAIR_W-1:0]          pair_r, pair_d;
    logic [CNT_W-1:0]           dwell, dwell_nxt;
    scan_state_t                state, state_nxt;
    logic                       pair_valid, pair_changed, capture;
    logic [IDX_W-1:0]           cap_idx;
    seg_decode_t                dec;
    logic [NUM_DIGITS-1:0]      mask, mask_nxt;
    logic                       complete;
    logic [NUM_DIGITS-1:0][3:0] slot_nib, value_r;
    logic [NUM_DIGITS-1:0]      slot_blank, blank_r;
    logic                       frame_valid_r, err_r, overrun_r;
    logic [IDX_W-1:0]           err_digit_r;

    assign pair_valid   = $onehot(~pair_r[PAIR_W-1:7]);
    assign pair_changed = (pair_r != pair_d);
    assign complete     = &mask;

    seg7_pattern_decode u_decode (
        .pattern  (pair_r[6:0]),
        .result_c (dec)
    );

    // Index of the selected digit (the single low anode)
    always_comb begin
        cap_idx = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (!pair_r[7 + i]) cap_idx = IDX_W'(i);
        end
    end

    // Dwell count: the first cycle of a new valid pair already counts as one
    always_comb begin
        dwell_nxt = dwell;
        if (!pair_valid)             dwell_nxt = '0;
        else if (pair_changed)       dwell_nxt = CNT_W'(1);
        else if (dwell != DWELL_MAX) dwell_nxt = dwell + CNT_W'(1);
    end

    // Input pair register and dwell counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_r <= '0;
            pair_d <= '0;
            dwell  <= '0;
        end else begin
            pair_r <= {bus.an_i, bus.seg_i};
            pair_d <= pair_r;
            dwell  <= dwell_nxt;
        end
    end

    // Scan FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Scan FSM next state; one capture per dwell, taken on the S_DWELL -> S_HELD edge
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (pair_valid) state_nxt = S_DWELL;
            end
            S_DWELL: begin
                if (!pair_valid || pair_changed) begin
                    state_nxt = S_IDLE;
                end else if (dwell_nxt == DWELL_MAX) begin
                    state_nxt = S_HELD;
                    capture   = 1'b1;
                end
            end
            S_HELD: begin
                if (!pair_valid)       state_nxt = S_IDLE;
                else if (pair_changed) state_nxt = S_DWELL;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Frame mask: cleared on completion, then this cycle's good capture is added
    always_comb begin
        mask_nxt = complete ? '0 : mask;
        if (capture && !dec.err) mask_nxt[cap_idx] = 1'b1;
    end

    // Slots, error tracking and output handshake; clear wins over everything here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask          <= '0;
            slot_nib      <= '0;
            slot_blank    <= '0;
            value_r       <= '0;
            blank_r       <= '0;
            frame_valid_r <= 1'b0;
            err_r         <= 1'b0;
            err_digit_r   <= '0;
            overrun_r     <= 1'b0;
        end else if (bus.clear_i) begin
            mask          <= '0;
            frame_valid_r <= 1'b0;
            err_r         <= 1'b0;
            err_digit_r   <= '0;
            overrun_r     <= 1'b0;
        end else begin
            mask <= mask_nxt;
            if (capture) begin
                if (dec.err) begin
                    err_r <= 1'b1;
                    if (!err_r) err_digit_r <= cap_idx;
                end else begin
                    slot_nib[cap_idx]   <= dec.nibble;
                    slot_blank[cap_idx] <= dec.blank;
                end
            end
            if (complete) begin
                if (!frame_valid_r || bus.frame_ready_i) begin
                    value_r       <= slot_nib;
                    blank_r       <= slot_blank;
                    frame_valid_r <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (frame_valid_r && bus.frame_ready_i) begin
                frame_valid_r <= 1'b0;
            end
        end
    end

    assign bus.value_o       = value_r;
    assign bus.blank_o       = blank_r;
    assign bus.frame_valid_o = frame_valid_r;
    assign bus.err_o         = err_r;
    assign bus.err_digit_o   = err_digit_r;
    assign bus.overrun_o     = overrun_r;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture with a frame scoreboard.
module tb_seg7_scan_capture;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  blank;
    } frame_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   frames_seen;
    int   valid_cycles;
    frame_t     exp_q[$];
    logic [6:0] enc_tab [16];

    seg7_scan_capture_if #(.NUM_DIGITS(4)) bus ();

    seg7_scan_capture #(
        .NUM_DIGITS    (4),
        .STABLE_CYCLES (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: a frame is accepted at the coming edge when valid && ready
    task automatic monitor();
        frame_t f;
        if (bus.frame_valid_o === 1'b1) valid_cycles++;
        if (bus.frame_valid_o === 1'b1 && bus.frame_ready_i === 1'b1) begin
            frames_seen++;
            check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                f = exp_q.pop_front();
                check("sb_value", 32'(bus.value_o), 32'(f.value));
                check("sb_blank", 32'(bus.blank_o), 32'(f.blank));
            end
        end
    endtask

    // Inputs are set at a falling edge; monitor, then advance to the next falling edge
    task automatic tick();
        monitor();
        @(negedge clk);
    endtask

    task automatic show(input int k, input logic [6:0] pat, input int cycles);
        logic [3:0] a;
        a        = 4'b1111;
        a[k]     = 1'b0;
        bus.an_i  = a;
        bus.seg_i = pat;
        repeat (cycles) tick();
    endtask

    task automatic idle(input int cycles);
        bus.an_i  = 4'b1111;
        bus.seg_i = 7'h7F;
        repeat (cycles) tick();
    endtask

    task automatic scan_frame(input logic [15:0] v);
        logic [3:0] nib;
        for (int k = 0; k < 4; k++) begin
            nib = v[4*k +: 4];
            show(k, enc_tab[nib], 20);
        end
    endtask

    task automatic pulse_clear();
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_value"},   32'(bus.value_o),       32'h0);
        check({tag, "_blank"},   32'(bus.blank_o),       32'h0);
        check({tag, "_valid"},   32'(bus.frame_valid_o), 32'h0);
        check({tag, "_err"},     32'(bus.err_o),         32'h0);
        check({tag, "_errdig"},  32'(bus.err_digit_o),   32'h0);
        check({tag, "_overrun"}, 32'(bus.overrun_o),     32'h0);
    endtask

    initial begin
        int f0;
        errors       = 0;
        checks       = 0;
        frames_seen  = 0;
        valid_cycles = 0;
        enc_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        rst_n             = 1'b0;
        bus.an_i          = 4'b1111;
        bus.seg_i         = 7'h7F;
        bus.clear_i       = 1'b0;
        bus.frame_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Basic frame 3210, ready high: one-cycle valid pulse
        valid_cycles = 0;
        exp_q.push_back('{value: 16'h3210, blank: 4'h0});
        scan_frame(16'h3210);
        idle(4);
        check("t1_frames", 32'(frames_seen), 32'd1);
        check("t1_valid_cycles", 32'(valid_cycles), 32'd1);
        check("t1_value_held", 32'(bus.value_o), 32'h3210);

        // Short dwell on digit 1: no capture, no frame until rescan
        f0 = frames_seen;
        show(0, enc_tab[1], 20);
        show(1, enc_tab[2], 10);
        show(2, enc_tab[3], 20);
        show(3, enc_tab[4], 20);
        idle(4);
        check("t2_no_frame", 32'(frames_seen), 32'(f0));
        exp_q.push_back('{value: 16'h4321, blank: 4'h0});
        scan_frame(16'h4321);
        idle(4);
        check("t2_rescan_frame", 32'(frames_seen), 32'(f0 + 1));
        pulse_clear();

        // Undecodable pattern on digit 2; first error index is sticky
        f0 = frames_seen;
        show(0, enc_tab[9], 20);
        show(1, enc_tab[12], 20);
        show(2, 7'h55, 20);
        show(3, enc_tab[10], 20);
        idle(4);
        check("t3_err", 32'(bus.err_o), 32'd1);
        check("t3_err_digit", 32'(bus.err_digit_o), 32'd2);
        check("t3_no_frame", 32'(frames_seen), 32'(f0));
        show(1, 7'h2A, 20);
        check("t3_err_digit_sticky", 32'(bus.err_digit_o), 32'd2);
        exp_q.push_back('{value: 16'hA5C9, blank: 4'h0});
        scan_frame(16'hA5C9);
        idle(4);
        check("t3_frame", 32'(frames_seen), 32'(f0 + 1));
        check("t3_err_still", 32'(bus.err_o), 32'd1);
        pulse_clear();
        check("t3_clear_err", 32'(bus.err_o), 32'd0);
        check("t3_clear_errdig", 32'(bus.err_digit_o), 32'd0);

        // Back-pressure: frame A held, frame B dropped with overrun
        bus.frame_ready_i = 1'b0;
        exp_q.push_back('{value: 16'hBEEF, blank: 4'h0});
        scan_frame(16'hBEEF);
        idle(2);
        check("t4_valid_a", 32'(bus.frame_valid_o), 32'd1);
        check("t4_value_a", 32'(bus.value_o), 32'hBEEF);
        check("t4_no_overrun_yet", 32'(bus.overrun_o), 32'd0);
        scan_frame(16'h1234);
        idle(2);
        check("t4_value_held", 32'(bus.value_o), 32'hBEEF);
        check("t4_overrun", 32'(bus.overrun_o), 32'd1);
        check("t4_valid_held", 32'(bus.frame_valid_o), 32'd1);
        bus.frame_ready_i = 1'b1;
        tick();
        check("t4_valid_drop", 32'(bus.frame_valid_o), 32'd0);
        pulse_clear();
        check("t4_clear_overrun", 32'(bus.overrun_o), 32'd0);

        // Blank digit 3
        exp_q.push_back('{value: 16'h0FFF, blank: 4'b1000});
        show(0, 7'h0E, 20);
        show(1, 7'h0E, 20);
        show(2, 7'h0E, 20);
        show(3, 7'h7F, 20);
        idle(2);
        check("t5_value", 32'(bus.value_o), 32'h0FFF);
        check("t5_blank", 32'(bus.blank_o), 32'h8);
        pulse_clear();

        // Reset mid-scan with two digits captured: must rescan all four
        show(0, enc_tab[4], 20);
        show(1, enc_tab[5], 20);
        show(2, enc_tab[6], 8);
        rst_n = 1'b0;
        tick();
        check_all_zero("t6_reset");
        tick();
        rst_n = 1'b1;
        f0 = frames_seen;
        show(2, enc_tab[6], 20);
        show(3, enc_tab[7], 20);
        idle(4);
        check("t6_no_frame", 32'(frames_seen), 32'(f0));
        check("t6_valid_low", 32'(bus.frame_valid_o), 32'd0);
        exp_q.push_back('{value: 16'h7654, blank: 4'h0});
        show(0, enc_tab[4], 20);
        show(1, enc_tab[5], 20);
        idle(4);
        check("t6_frame", 32'(frames_seen), 32'(f0 + 1));

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
